// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU: opcodes, controller states, ALU ops and datapath selects.
// Used by the controller, the ALU control and the datapath top.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_FUNCT = 3'd2,
        ALU_SLT   = 3'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_B_REG     = 2'd0,
        SRC_B_FOUR    = 2'd1,
        SRC_B_IMM     = 2'd2,
        SRC_B_IMM_SH2 = 2'd3
    } src_b_t;

    typedef enum logic [1:0] {
        PC_SRC_ALU     = 2'd0,
        PC_SRC_ALU_OUT = 2'd1,
        PC_SRC_JUMP    = 2'd2
    } pc_src_t;

    // One bundle of every control output, so the whole set can be cleared in one assignment.
    typedef struct packed {
        logic    pc_write;
        logic    pc_write_cond;
        pc_src_t pc_source;
        logic    i_or_d;
        logic    mem_read;
        logic    mem_write;
        logic    ir_write;
        logic    mem_to_reg;
        logic    reg_dst;
        logic    reg_write;
        logic    alu_src_a;
        src_b_t  alu_src_b;
        alu_op_t alu_op;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, selects and enables out.
interface multicycle_ctrl_if;

    logic [5:0]  opcode_i;
    logic        mem_ready_i;
    logic        pc_write_o;
    logic        pc_write_cond_o;
    logic [1:0]  pc_source_o;
    logic        i_or_d_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        ir_write_o;
    logic        mem_to_reg_o;
    logic        reg_dst_o;
    logic        reg_write_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic        illegal_o;
    logic [3:0]  state_o;
    logic [31:0] retired_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, illegal_o, state_o, retired_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, illegal_o, state_o, retired_o
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute over a shared memory port and ALU,
// stalls on mem_ready_i and counts retired instructions.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;
    ctrl_t       ctl;
    ctrl_t       ctl_out;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        ctl     = '0;
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRC_B_FOUR;
                if (bus.mem_ready_i) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target; harmless for non-branch opcodes.
                ctl.alu_src_b = SRC_B_IMM_SH2;
                unique case (bus.opcode_i)
                    OP_LW, OP_SW:       state_d = S_MEM_ADDR;
                    OP_RTYPE:           state_d = S_EXEC_R;
                    OP_ADDI, OP_SLTI:   state_d = S_EXEC_I;
                    OP_BEQ:             state_d = S_BRANCH;
                    OP_J:               state_d = S_JUMP;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_IMM;
                state_d       = (bus.opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (bus.mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (bus.mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_REG;
                ctl.alu_op    = ALU_FUNCT;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = (bus.opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d       = S_I_WB;
            end
            S_I_WB: begin
                ctl.reg_write = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRC_B_REG;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PC_SRC_ALU_OUT;
                retire            = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PC_SRC_JUMP;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign retired_d = retired_q + {31'd0, retire};

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Reset overrides the FETCH decode so no strobe escapes while rst_i is high.
    assign ctl_out = rst_i ? '0 : ctl;

    assign bus.pc_write_o      = ctl_out.pc_write;
    assign bus.pc_write_cond_o = ctl_out.pc_write_cond;
    assign bus.pc_source_o     = ctl_out.pc_source;
    assign bus.i_or_d_o        = ctl_out.i_or_d;
    assign bus.mem_read_o      = ctl_out.mem_read;
    assign bus.mem_write_o     = ctl_out.mem_write;
    assign bus.ir_write_o      = ctl_out.ir_write;
    assign bus.mem_to_reg_o    = ctl_out.mem_to_reg;
    assign bus.reg_dst_o       = ctl_out.reg_dst;
    assign bus.reg_write_o     = ctl_out.reg_write;
    assign bus.alu_src_a_o     = ctl_out.alu_src_a;
    assign bus.alu_src_b_o     = ctl_out.alu_src_b;
    assign bus.alu_op_o        = ctl_out.alu_op;
    assign bus.illegal_o       = ctl_out.illegal;
    assign bus.state_o         = state_q;
    assign bus.retired_o       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected state/controls/count per cycle,
// a monitor pops and compares them at every falling edge.
module tb_multicycle_ctrl;

    typedef logic [17:0] ctl_t;

    typedef struct packed {
        logic [3:0]  st;
        ctl_t        c;
        logic [31:0] ret;
    } exp_t;

    // Field order: pc_write, pc_write_cond, pc_source[2], i_or_d, mem_read, mem_write, ir_write,
    //              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[3], illegal
    localparam ctl_t C_ZERO    = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0};
    localparam ctl_t C_F_WAIT  = {1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,3'd0,1'b0};
    localparam ctl_t C_F_RDY   = {1'b1,1'b0,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,3'd0,1'b0};
    localparam ctl_t C_DEC     = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,3'd0,1'b0};
    localparam ctl_t C_DEC_ILL = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,3'd0,1'b1};
    localparam ctl_t C_MADDR   = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd0,1'b0};
    localparam ctl_t C_MRD     = {1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0};
    localparam ctl_t C_MWB     = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,3'd0,1'b0};
    localparam ctl_t C_MWR     = {1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0};
    localparam ctl_t C_EXR     = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,3'd2,1'b0};
    localparam ctl_t C_RWB     = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,3'd0,1'b0};
    localparam ctl_t C_EXI_ADD = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd0,1'b0};
    localparam ctl_t C_EXI_SLT = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd3,1'b0};
    localparam ctl_t C_IWB     = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,3'd0,1'b0};
    localparam ctl_t C_BR      = {1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,3'd1,1'b0};
    localparam ctl_t C_JMP     = {1'b1,1'b0,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b0};

    localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the expectation describes what the DUT shows for the rest of this cycle.
    task automatic cyc(input logic r, input logic rdy, input logic [5:0] op,
                       input logic [3:0] st, input ctl_t c, input logic [31:0] ret);
        @(posedge clk);
        #1;
        rst             = r;
        bus.mem_ready_i = rdy;
        bus.opcode_i    = op;
        sb_q.push_back('{st: st, c: c, ret: ret});
    endtask

    initial begin : monitor
        exp_t e;
        ctl_t act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {bus.pc_write_o, bus.pc_write_cond_o, bus.pc_source_o, bus.i_or_d_o,
                       bus.mem_read_o, bus.mem_write_o, bus.ir_write_o, bus.mem_to_reg_o,
                       bus.reg_dst_o, bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
                       bus.alu_op_o, bus.illegal_o};
                check("state", {28'd0, bus.state_o}, {28'd0, e.st});
                check("ctrl", {14'd0, act}, {14'd0, e.c});
                check("retired", bus.retired_o, e.ret);
            end
        end
    end

    initial begin : stimulus
        bus.opcode_i    = 6'h00;
        bus.mem_ready_i = 1'b0;

        // Reset holds everything low, even with ready high
        cyc(1, 0, 6'h00, 4'd0, C_ZERO, 0);
        cyc(1, 1, 6'h00, 4'd0, C_ZERO, 0);

        // R-type, zero wait
        cyc(0, 1, 6'h00, 4'd0, C_F_RDY, 0);
        cyc(0, 1, 6'h00, 4'd1, C_DEC,   0);
        cyc(0, 1, 6'h00, 4'd6, C_EXR,   0);
        cyc(0, 1, 6'h00, 4'd7, C_RWB,   0);

        // lw with two wait cycles in MEM_RD
        cyc(0, 1, 6'h23, 4'd0, C_F_RDY, 1);
        cyc(0, 1, 6'h23, 4'd1, C_DEC,   1);
        cyc(0, 1, 6'h23, 4'd2, C_MADDR, 1);
        cyc(0, 0, 6'h23, 4'd3, C_MRD,   1);
        cyc(0, 0, 6'h23, 4'd3, C_MRD,   1);
        cyc(0, 1, 6'h23, 4'd3, C_MRD,   1);
        cyc(0, 1, 6'h23, 4'd4, C_MWB,   1);

        // sw with a three-cycle FETCH stall, then one wait in MEM_WR
        cyc(0, 0, 6'h2B, 4'd0, C_F_WAIT, 2);
        cyc(0, 0, 6'h2B, 4'd0, C_F_WAIT, 2);
        cyc(0, 0, 6'h2B, 4'd0, C_F_WAIT, 2);
        cyc(0, 1, 6'h2B, 4'd0, C_F_RDY,  2);
        cyc(0, 1, 6'h2B, 4'd1, C_DEC,    2);
        cyc(0, 1, 6'h2B, 4'd2, C_MADDR,  2);
        cyc(0, 0, 6'h2B, 4'd5, C_MWR,    2);
        cyc(0, 1, 6'h2B, 4'd5, C_MWR,    2);

        // addi
        cyc(0, 1, 6'h08, 4'd0,  C_F_RDY,   3);
        cyc(0, 1, 6'h08, 4'd1,  C_DEC,     3);
        cyc(0, 1, 6'h08, 4'd10, C_EXI_ADD, 3);
        cyc(0, 1, 6'h08, 4'd11, C_IWB,     3);

        // slti with ready low where it must be ignored
        cyc(0, 1, 6'h0A, 4'd0,  C_F_RDY,   4);
        cyc(0, 0, 6'h0A, 4'd1,  C_DEC,     4);
        cyc(0, 0, 6'h0A, 4'd10, C_EXI_SLT, 4);
        cyc(0, 0, 6'h0A, 4'd11, C_IWB,     4);

        // beq, j: three cycles each
        cyc(0, 1, 6'h04, 4'd0, C_F_RDY, 5);
        cyc(0, 1, 6'h04, 4'd1, C_DEC,   5);
        cyc(0, 1, 6'h04, 4'd8, C_BR,    5);
        cyc(0, 1, 6'h02, 4'd0, C_F_RDY, 6);
        cyc(0, 1, 6'h02, 4'd1, C_DEC,   6);
        cyc(0, 1, 6'h02, 4'd9, C_JMP,   6);

        // Illegal opcode: one-cycle pulse, back to FETCH, no retire
        cyc(0, 1, 6'h3F, 4'd0, C_F_RDY,   7);
        cyc(0, 1, 6'h3F, 4'd1, C_DEC_ILL, 7);
        cyc(0, 0, 6'h02, 4'd0, C_F_WAIT,  7);

        // Counter wrap: preload all-ones, then retire a jump
        @(negedge clk);
        #1;
        force dut.retired_q = ALL1;
        #1;
        release dut.retired_q;
        cyc(0, 0, 6'h02, 4'd0, C_F_WAIT, ALL1);
        cyc(0, 1, 6'h02, 4'd0, C_F_RDY,  ALL1);
        cyc(0, 1, 6'h02, 4'd1, C_DEC,    ALL1);
        cyc(0, 1, 6'h02, 4'd9, C_JMP,    ALL1);
        cyc(0, 0, 6'h02, 4'd0, C_F_WAIT, 0);

        // Reset in the middle of MEM_RD aborts at once; fetch resumes after release
        cyc(0, 1, 6'h23, 4'd0, C_F_RDY,  0);
        cyc(0, 1, 6'h23, 4'd1, C_DEC,    0);
        cyc(0, 1, 6'h23, 4'd2, C_MADDR,  0);
        cyc(0, 0, 6'h23, 4'd3, C_MRD,    0);
        cyc(1, 0, 6'h23, 4'd0, C_ZERO,   0);
        cyc(0, 0, 6'h23, 4'd0, C_F_WAIT, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control state machine that sequences a shared multi-cycle datapath: one memory port for instructions and data, one ALU for PC increment, branch target and execution, and registered IR/A/B/ALUOut stages. The block decodes the opcode latched in the IR and drives every datapath select and write enable cycle by cycle. It stalls on a memory ready handshake and counts retired instructions. It replaces the single-cycle decoder when the CPU moves to the multi-cycle organisation.

## Interface
- No parameters. Opcode, state and ALU-op encodings come from the shared package.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- opcode_i  in  6  IR[31:26], valid from DECODE onward
- mem_ready_i  in  1  memory completes the current read or write this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load qualified by ALU zero (beq)
- pc_source_o  out  2  0: ALU result, 1: ALUOut, 2: jump target
- i_or_d_o  out  1  memory address select; 0: PC, 1: ALUOut
- mem_read_o, mem_write_o  out  1 each  memory strobes
- ir_write_o  out  1  IR load
- mem_to_reg_o  out  1  register write-data select; 0: ALUOut, 1: MDR
- reg_dst_o  out  1  destination select; 0: rt, 1: rd
- reg_write_o  out  1  register file write
- alu_src_a_o  out  1  ALU operand A; 0: PC, 1: A
- alu_src_b_o  out  2  ALU operand B; 0: B, 1: const 4, 2: sign-extended immediate, 3: sign-extended immediate << 2
- alu_op_o  out  3  0: add, 1: sub, 2: funct-decoded (R-type), 3: slt
- illegal_o  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state_o  out  4  current state, for debug
- retired_o  out  32  count of completed instructions

## Operation
- Supported opcodes: R-type 0x00, addi 0x08, slti 0x0A, beq 0x04, j 0x02, lw 0x23, sw 0x2B.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, EXEC_I 10, I_WB 11.
- **FETCH**
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_source=0.
  - ir_write and pc_write assert only in the cycle mem_ready_i=1. That cycle advances to DECODE; otherwise the state holds.
- **DECODE**
  - Drives alu_src_a=0, alu_src_b=3, alu_op=add to form the branch target into ALUOut.
  - Next state by opcode:
    - lw or sw → MEM_ADDR
    - R-type → EXEC_R
    - addi or slti → EXEC_I
    - beq → BRANCH
    - j → JUMP
    - any other opcode → FETCH, with illegal_o=1 and no write enables.
- **MEM_ADDR**: alu_src_a=1, alu_src_b=2, alu_op=add. Goes to MEM_RD for lw, MEM_WR for sw.
- **MEM_RD**: mem_read=1, i_or_d=1. Holds until mem_ready_i, then goes to MEM_WB.
- **MEM_WB**: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- **MEM_WR**: mem_write=1, i_or_d=1. Holds until mem_ready_i, then goes to FETCH.
- **EXEC_R**: alu_src_a=1, alu_src_b=0, alu_op=2. Goes to R_WB.
- **R_WB**: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- **EXEC_I**: alu_src_a=1, alu_src_b=2, alu_op=add for addi or slt for slti. Goes to I_WB.
- **I_WB**: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- **BRANCH**: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_source=1. Goes to FETCH.
- **JUMP**: pc_write=1, pc_source=2. Goes to FETCH.
- Any output not listed for a state is 0.
- opcode_i is sampled in every post-FETCH state, so the datapath must hold the IR stable from DECODE until the return to FETCH.
- retired_o increments by 1 on the transition into FETCH from MEM_WB, MEM_WR (with ready), R_WB, I_WB, BRANCH or JUMP.
  - An illegal opcode does not retire.
  - Wraps 0xFFFFFFFF → 0.

## Timing
- **Reset**
  - While rst_i=1: state=FETCH, retired_o=0, and every strobe and write-enable output is forced to 0. This includes mem_read_o.
  - Select outputs (pc_source_o, i_or_d_o, mem_to_reg_o, reg_dst_o, alu_src_a_o, alu_src_b_o, alu_op_o) are also forced to 0 while rst_i=1.
  - First fetch is issued in the cycle after deassertion.
  - Reset mid-instruction aborts immediately; no partial write completes after the asynchronous edge.
- **Output timing**
  - Outputs are combinational from the state register, plus opcode_i and mem_ready_i where stated.
  - No output depends on any other input.
- **Latency with zero memory wait** (mem_ready_i high on the first cycle):

| Instruction | Cycles |
|---|---|
| j, beq | 3 |
| R-type, addi, slti, sw | 4 |
| lw | 5 |
| illegal opcode | 2 |

- Each cycle mem_ready_i stays low in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready_i is ignored in all other states.
- illegal_o is high for exactly one cycle per illegal instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams
  - the 4-bit state encoding
  - ALU-op codes
  - alu_src_b and pc_source encodings
- These are shared with the ALU control and the datapath top.
- Single module. The instruction counter is inline and needs no sub-module.

## Test plan
- **Reset**: assert rst_i mid-MEM_RD → state_o=0, mem_read_o=0 and retired_o=0 immediately. After release, the first cycle shows mem_read_o=1, i_or_d_o=0.
- **R-type, zero wait**: opcode 0x00 with mem_ready_i held 1 → state_o sequence 0,1,6,7,0; reg_write_o=1 and reg_dst_o=1 only in state 7; retired_o=1.
- **lw with two-cycle memory wait**: opcode 0x23 with ready low for 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,4,0 (7 cycles); mem_to_reg_o=1 in state 4.
- **FETCH stall**: mem_ready_i low for 3 cycles in FETCH → ir_write_o and pc_write_o stay 0 for those 3 cycles, then both are 1 for exactly one cycle.
- **beq and j**: beq → pc_write_cond_o=1, pc_source_o=1, alu_op_o=1 in state 8. j → pc_write_o=1, pc_source_o=2 in state 9. Each takes 3 cycles.
- **Illegal opcode and counter wrap**
  - opcode 0x3F → illegal_o high for one cycle, return to FETCH, no write enables, retired_o unchanged.
  - Preload the counter by running 2^32−1 instructions (or force it) → next retire gives retired_o=0.
